// File: rtl/demux_1x8_sched.sv
// demux_1x8_sched: one-word-deep 1-to-8 demultiplexer with round-robin
// channel scheduling. An accepted upstream word is held in out_data and
// presented on exactly one channel (one-hot out_valid) until that channel's
// out_ready completes the transfer.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data, in_valid   upstream payload and valid
//   in_ready            upstream ready (combinational: depends on out_ready[sel])
//   out_data            held payload shared by all channels
//   out_valid[7:0]      one-hot per-channel valid
//   out_ready[7:0]      per-channel ready
//   sel[2:0]            currently targeted channel (demux tree select)
//   busy                a word is held
//   xfer_cnt            completed downstream transfers, wraps
//   chan_en[7:0]        channel eligibility mask (only with DEMUX_SCHED_MASK_EN)
//
// Build option: define DEMUX_SCHED_MASK_EN to add chan_en masking; otherwise
// all eight channels are always eligible.

module demux_1x8_sched #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [7:0]        out_valid,
    input  logic [7:0]        out_ready,
    output logic [2:0]        sel,
    output logic              busy,
    output logic [CNT_W-1:0]  xfer_cnt
`ifdef DEMUX_SCHED_MASK_EN
    ,
    input  logic [7:0]        chan_en
`endif
);

    localparam int unsigned N_CH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state;
    logic [2:0]        rr_ptr;
    logic [N_CH-1:0]   elig;
    logic              any_elig;
    logic              done;
    logic              accept;
    logic [2:0]        base;
    logic [2:0]        target;
    logic              found;

`ifdef DEMUX_SCHED_MASK_EN
    assign elig = chan_en;
`else
    assign elig = '1;
`endif

    assign any_elig = |elig;
    assign busy     = (state == HOLD);

    // Held word leaves when its latched channel is ready, regardless of chan_en.
    assign done = (state == HOLD) && out_ready[sel];

    // Gated by rst_n so in_ready drops immediately while reset is asserted.
    assign in_ready = rst_n && any_elig && ((state == IDLE) || out_ready[sel]);
    assign accept   = in_valid && in_ready;

    // On a back-to-back transfer the search starts after the departing channel.
    assign base = done ? (sel + 3'd1) : rr_ptr;

    // First eligible channel found searching circularly upward from base.
    always_comb begin
        target = base;
        found  = 1'b0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (!found && elig[base + 3'(i)]) begin
                target = base + 3'(i);
                found  = 1'b1;
            end
        end
    end

    // State, held word and scheduling bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_data  <= '0;
            out_valid <= '0;
            sel       <= '0;
            rr_ptr    <= '0;
            xfer_cnt  <= '0;
        end else begin
            if (done) begin
                rr_ptr   <= sel + 3'd1;
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
            if (accept) begin
                state     <= HOLD;
                out_data  <= in_data;
                sel       <= target;
                out_valid <= 8'(1) << target;
            end else if (done) begin
                state     <= IDLE;
                out_valid <= '0;
            end
        end
    end

endmodule

// File: doc/demux_1x8_sched.md
DEMUX_1X8_SCHED -- requirements
Module: demux_1x8_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the payload width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, giving the transfer counter width in bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream word present.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-008 SHALL have port out_data, output, DATA_W bits: held payload, shared by all 8 channels.
REQ-009 SHALL have port out_valid, output, 8 bits: one-hot per-channel valid.
REQ-010 SHALL have port out_ready, input, 8 bits: per-channel ready.
REQ-011 SHALL have port sel, output, 3 bits: the currently targeted channel, which drives the demux tree select lines.
REQ-012 SHALL have port busy, output, 1 bit: a word is held (state HOLD).
REQ-013 SHALL have port xfer_cnt, output, CNT_W bits: completed downstream transfers.

Function
REQ-014 SHALL have the states IDLE (no word held) and HOLD (one word held in the output register).
REQ-015 SHALL drive in_ready=1 in IDLE when at least one channel is eligible.
REQ-016 SHALL drive in_ready=1 in HOLD only when out_ready[sel]=1 and at least one channel is eligible.
REQ-017 SHALL define an accept as in_valid & in_ready at a rising clk edge.
REQ-018 On accept, SHALL latch in_data into out_data, load sel with the target channel, and set out_valid to the one-hot of that channel, all on the same edge.
REQ-019 SHALL choose as the target the first eligible channel found by searching circularly upward from rr_ptr (7 wraps to 0).
REQ-020 SHALL hold rr_ptr internally, 3 bits.
REQ-021 SHALL treat a downstream transfer as complete in HOLD when out_ready[sel]=1.
REQ-022 On transfer completion, SHALL set rr_ptr to sel+1 mod 8 and increment xfer_cnt, wrapping modulo 2^CNT_W.
REQ-023 On transfer completion with a simultaneous accept, SHALL stay in HOLD and start the new target search from the old sel+1, giving one word per cycle with no bubble.
REQ-024 On transfer completion without an accept, SHALL go to IDLE, clear out_valid to 0, and keep the sel and out_data values.
REQ-025 SHALL hold out_data, sel and out_valid stable in HOLD until the transfer completes.
REQ-026 SHALL leave in_valid=0 in IDLE with no effect.
REQ-027 SHALL have out_valid zero or one-hot at all times.
REQ-028 SHALL drive busy=1 exactly in HOLD.

Reset
REQ-029 On rst_n=0, SHALL immediately, without waiting for clk, force state IDLE, out_valid=0, out_data=0, sel=0, rr_ptr=0, xfer_cnt=0, busy=0 and in_ready=0.
REQ-030 SHALL discard a word held at reset, with no downstream transfer counted.
REQ-031 SHALL take the first possible accept at the first rising clk edge after rst_n deasserts, and SHALL have in_ready=1 during the cycle before that edge.

Configuration
REQ-032 SHALL use the macro DEMUX_SCHED_MASK_EN to add or remove channel masking.
REQ-033 With DEMUX_SCHED_MASK_EN defined, SHALL add the input port chan_en, 8 bits, and treat channel i as eligible only when chan_en[i]=1.
REQ-034 With DEMUX_SCHED_MASK_EN defined and chan_en=0, SHALL drive in_ready=0.
REQ-035 With DEMUX_SCHED_MASK_EN defined, SHALL still deliver a held word to the latched sel when chan_en changes during HOLD.
REQ-036 With DEMUX_SCHED_MASK_EN undefined, SHALL have no chan_en port and treat all 8 channels as eligible.

Verification
REQ-037 SHALL cover: reset, then out_ready=8'hFF, in_valid=1 for 10 cycles with data 1..10 -> words on channels 0,1,..,7,0,1, one per cycle, xfer_cnt=10.
REQ-038 SHALL cover: one word 8'hA5 with out_ready=0 for 5 cycles, then out_ready[0]=1 -> out_valid=8'h01 and out_data=8'hA5 stable for 5 cycles, in_ready=0, transfer on cycle 6, then IDLE.
REQ-039 SHALL cover, with DEMUX_SCHED_MASK_EN defined: chan_en=8'b1000_0100 and 4 words -> channels 2,7,2,7.
REQ-040 SHALL cover, with DEMUX_SCHED_MASK_EN defined: chan_en=0 -> in_ready=0 and no out_valid.
REQ-041 SHALL cover, with DEMUX_SCHED_MASK_EN defined: chan_en cleared during HOLD on channel 3 -> the word still completes on channel 3.
REQ-042 SHALL cover: rst_n pulsed low mid-clock in HOLD -> out_valid=0 and sel=0 immediately, xfer_cnt=0, next word goes to channel 0.
REQ-043 SHALL cover: xfer_cnt preset near wrap (CNT_W=4) with 17 transfers -> xfer_cnt=1.
